pipe_ctrl_hz: RTL and testbench

- Next-generation pipelined RV32I control unit: instruction decode, control pipeline D→E→M→W, and an integrated hazard unit (load-use stall, branch flush, operand forwarding).
- Adds over the previous controller: extended branch set, jalr and lui support, register-address tracking, and internally generated stall/flush/forward controls instead of an external FlushE.
- Sits between the instruction register (decode stage) and the five-stage datapath.

---
 rtl/pipe_ctrl_hz_pkg.sv | 71 +++++++
 rtl/pipe_ctrl_hz_unit.sv | 56 +++++
 rtl/pipe_ctrl_hz.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl_hz.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_hz_pkg.sv
// Shared encodings and the control-word layout for the pipelined RV32I
// controller and its hazard unit.
package pipe_ctrl_hz_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       pcTgtSrc;
    logic [3:0] aluControl;
    logic       aluSrc;
    logic [2:0] funct3;
  } ctrlWord_t;

  // alt selects sub/sra; the caller decides when funct7[5] is meaningful.
  function automatic logic [3:0] aluDecode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_hz_unit.sv
// Hazard unit: load-use / RAW stalls, branch flushes and operand forwarding
// selects for the execute stage.
module pipe_hz_unit
  import pipe_ctrl_hz_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic [RA_W-1:0] rs1D,
  input  logic [RA_W-1:0] rs2D,
  input  logic [RA_W-1:0] rs1E,
  input  logic [RA_W-1:0] rs2E,
  input  logic [RA_W-1:0] rdE,
  input  logic [RA_W-1:0] rdM,
  input  logic [RA_W-1:0] rdW,
  input  logic            regWriteE,
  input  logic [1:0]      resultSrcE,
  input  logic            regWriteM,
  input  logic            regWriteW,
  input  logic            pcSrcE,
  output logic            stall,
  output logic            flushD,
  output logic            flushE,
  output logic [1:0]      forwardA,
  output logic [1:0]      forwardB
);

  logic lwStall;
  logic rawStall;

  // x0 is hardwired, so a producer targeting it never creates a dependency.
  function automatic logic hits(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  always_comb begin
    lwStall  = regWriteE && (resultSrcE == RES_MEM) && (hits(rdE, rs1D) || hits(rdE, rs2D));
    rawStall = 1'b0;
    forwardA = FWD_RF;
    forwardB = FWD_RF;
    if (FWD_EN != 0) begin
      if (regWriteM && hits(rdM, rs1E))      forwardA = FWD_M;
      else if (regWriteW && hits(rdW, rs1E)) forwardA = FWD_W;
      if (regWriteM && hits(rdM, rs2E))      forwardB = FWD_M;
      else if (regWriteW && hits(rdW, rs2E)) forwardB = FWD_W;
    end else begin
      // W needs no stall: the register file writes in the first half-cycle.
      rawStall = (regWriteE && (hits(rdE, rs1D) || hits(rdE, rs2D))) ||
                 (regWriteM && (hits(rdM, rs1D) || hits(rdM, rs2D)));
    end
    stall  = lwStall | rawStall;
    flushD = pcSrcE;
    flushE = stall | pcSrcE;
  end

endmodule

// File: rtl/pipe_ctrl_hz.sv
// Pipelined RV32I control unit: decode, D->E->M->W control pipeline and the
// integrated hazard unit.
module pipe_ctrl_hz
  import pipe_ctrl_hz_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int BR_EXT = 1,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic            ZeroE,
  input  logic            LtE,
  output logic [2:0]      ImmSrcD,
  output logic [3:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic            PCSrcE,
  output logic            PCTgtSrcE,
  output logic            MemWriteM,
  output logic            RegWriteW,
  output logic [RA_W-1:0] RdW,
  output logic [1:0]      ResultSrcW,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE
);

  ctrlWord_t       ctrlD, ctrlE;
  logic [2:0]      immSrc;
  logic [RA_W-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM;
  logic            regWriteM, memWriteM;
  logic [1:0]      resultSrcM;
  logic            taken, stall, flushE;
  logic            unusedInstr;

  assign rs1D        = RA_W'(InstrD[19:15]);
  assign rs2D        = RA_W'(InstrD[24:20]);
  assign rdD         = RA_W'(InstrD[11:7]);
  assign unusedInstr = ^{InstrD[31], InstrD[29:25]};

  always_comb begin
    ctrlD  = '0;
    immSrc = IMM_I;
    case (InstrD[6:0])
      OP_LW:   begin ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_MEM; ctrlD.aluSrc = 1'b1; end
      OP_SW:   begin ctrlD.memWrite = 1'b1; ctrlD.aluSrc = 1'b1; immSrc = IMM_S; end
      OP_R:    begin
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluControl = aluDecode(InstrD[14:12], InstrD[30]);
      end
      OP_I:    begin
        // Only srai carries funct7[5]; addi must never turn into sub.
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluSrc     = 1'b1;
        ctrlD.aluControl = aluDecode(InstrD[14:12], (InstrD[14:12] == 3'b101) && InstrD[30]);
      end
      OP_BR:   begin
        ctrlD.branch = 1'b1; ctrlD.aluControl = ALU_SUB;
        ctrlD.funct3 = InstrD[14:12]; immSrc = IMM_B;
      end
      OP_JAL:  begin
        ctrlD.jump = 1'b1; ctrlD.regWrite = 1'b1;
        ctrlD.resultSrc = RES_PC4; immSrc = IMM_J;
      end
      OP_JALR: begin
        ctrlD.jump = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.aluSrc = 1'b1;
        ctrlD.pcTgtSrc = 1'b1; ctrlD.resultSrc = RES_PC4;
      end
      OP_LUI:  begin ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_IMM; immSrc = IMM_U; end
      default: ;
    endcase
  end

  // Decode is combinational, so it is gated to keep every output low in reset.
  assign ImmSrcD = reset ? immSrc : IMM_I;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlE      <= '0;
      rs1E       <= '0;
      rs2E       <= '0;
      rdE        <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      resultSrcM <= RES_ALU;
      rdM        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= RES_ALU;
      RdW        <= '0;
    end else begin
      if (flushE) begin
        ctrlE <= '0;
        rs1E  <= '0;
        rs2E  <= '0;
        rdE   <= '0;
      end else begin
        ctrlE <= ctrlD;
        rs1E  <= rs1D;
        rs2E  <= rs2D;
        rdE   <= rdD;
      end
      regWriteM  <= ctrlE.regWrite;
      memWriteM  <= ctrlE.memWrite;
      resultSrcM <= ctrlE.resultSrc;
      rdM        <= rdE;
      RegWriteW  <= regWriteM;
      ResultSrcW <= resultSrcM;
      RdW        <= rdM;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (ctrlE.funct3)
      BR_EQ:   taken = ZeroE;
      BR_NE:   taken = (BR_EXT != 0) && !ZeroE;
      BR_LT:   taken = (BR_EXT != 0) && LtE;
      BR_GE:   taken = (BR_EXT != 0) && !LtE;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE      = (ctrlE.branch & taken) | ctrlE.jump;
  assign ALUControlE = ctrlE.aluControl;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign PCTgtSrcE   = ctrlE.pcTgtSrc;
  assign MemWriteM   = memWriteM;
  assign StallF      = stall;
  assign StallD      = stall;

  pipe_hz_unit #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_hz (
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .rdM        (rdM),
    .rdW        (RdW),
    .regWriteE  (ctrlE.regWrite),
    .resultSrcE (ctrlE.resultSrc),
    .regWriteM  (regWriteM),
    .regWriteW  (RegWriteW),
    .pcSrcE     (PCSrcE),
    .stall      (stall),
    .flushD     (FlushD),
    .flushE     (flushE),
    .forwardA   (ForwardAE),
    .forwardB   (ForwardBE)
  );

endmodule

// File: tb/tb_pipe_ctrl_hz.sv
// Directed bench for pipe_ctrl_hz: a forwarding instance (dut) and a
// stall-only instance (dutNf) share clock, reset and instruction stream.
module tb_pipe_ctrl_hz;

  logic        clk, reset, ZeroE, LtE;
  logic [31:0] InstrD;

  logic [2:0] ImmSrcD;     logic [3:0] ALUControlE; logic ALUSrcE, PCSrcE, PCTgtSrcE, MemWriteM, RegWriteW;
  logic [4:0] RdW;         logic [1:0] ResultSrcW;  logic StallF, StallD, FlushD;
  logic [1:0] ForwardAE, ForwardBE;

  logic [2:0] nImmSrcD;    logic [3:0] nALUControlE; logic nALUSrcE, nPCSrcE, nPCTgtSrcE, nMemWriteM, nRegWriteW;
  logic [4:0] nRdW;        logic [1:0] nResultSrcW;  logic nStallF, nStallD, nFlushD;
  logic [1:0] nForwardAE, nForwardBE;

  int nChecks = 0;
  int nFails  = 0;

  pipe_ctrl_hz #(.RA_W(5), .BR_EXT(1), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ZeroE(ZeroE), .LtE(LtE),
    .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE),
    .PCTgtSrcE(PCTgtSrcE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultSrcW(ResultSrcW), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  pipe_ctrl_hz #(.RA_W(5), .BR_EXT(1), .FWD_EN(0)) dutNf (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ZeroE(ZeroE), .LtE(LtE),
    .ImmSrcD(nImmSrcD), .ALUControlE(nALUControlE), .ALUSrcE(nALUSrcE), .PCSrcE(nPCSrcE),
    .PCTgtSrcE(nPCTgtSrcE), .MemWriteM(nMemWriteM), .RegWriteW(nRegWriteW), .RdW(nRdW),
    .ResultSrcW(nResultSrcW), .StallF(nStallF), .StallD(nStallD), .FlushD(nFlushD),
    .ForwardAE(nForwardAE), .ForwardBE(nForwardBE)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction encoders
  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] bType(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    InstrD = instr;
    #1;
  endtask

  task automatic drainPipe();
    InstrD = 32'h0;
    ZeroE  = 1'b0;
    LtE    = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [27:0] allOut, nAllOut;
    reset = 1'b0; ZeroE = 1'b1; LtE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive($urandom);
      allOut  = {ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, PCTgtSrcE, MemWriteM, RegWriteW, RdW,
                 ResultSrcW, StallF, StallD, FlushD, ForwardAE, ForwardBE};
      nAllOut = {nImmSrcD, nALUControlE, nALUSrcE, nPCSrcE, nPCTgtSrcE, nMemWriteM, nRegWriteW, nRdW,
                 nResultSrcW, nStallF, nStallD, nFlushD, nForwardAE, nForwardBE};
      nChecks++; if (allOut !== '0)  begin nFails++; $display("FAIL reset_outs got %h want 0", allOut); end
      nChecks++; if (nAllOut !== '0) begin nFails++; $display("FAIL reset_outs_nf got %h want 0", nAllOut); end
    end
    ZeroE = 1'b0; LtE = 1'b0;
    reset = 1'b1;
    drive(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd3));
    tick(); drive(32'h0);
    nChecks++; if (ALUControlE !== 4'b0000) begin nFails++; $display("FAIL first_aluctl got %b want 0000", ALUControlE); end
    nChecks++; if (RegWriteW !== 1'b0) begin nFails++; $display("FAIL first_early_regwr got %b want 0", RegWriteW); end
    tick();
    nChecks++; if (RegWriteW !== 1'b0) begin nFails++; $display("FAIL first_m_regwr got %b want 0", RegWriteW); end
    tick();
    nChecks++; if (RegWriteW !== 1'b1) begin nFails++; $display("FAIL first_w_regwr got %b want 1", RegWriteW); end
    nChecks++; if (RdW !== 5'd3) begin nFails++; $display("FAIL first_w_rd got %0d want 3", RdW); end
  endtask

  task automatic test_mid_reset();
    drainPipe();
    drive(iType(12'd5, 5'd1, 3'b000, 5'd9, 7'b0010011));
    tick(); drive(32'h0);
    nChecks++; if (ALUSrcE !== 1'b1) begin nFails++; $display("FAIL midrst_pre_alusrc got %b want 1", ALUSrcE); end
    reset = 1'b0; #1;
    nChecks++; if (ALUSrcE !== 1'b0) begin nFails++; $display("FAIL midrst_async_alusrc got %b want 0", ALUSrcE); end
    reset = 1'b1;
    tick(); tick();
    nChecks++; if (RegWriteW !== 1'b0) begin nFails++; $display("FAIL midrst_w_regwr got %b want 0", RegWriteW); end
  endtask

  task automatic test_load_use();
    drainPipe();
    drive(iType(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
    nChecks++; if (StallF !== 1'b0) begin nFails++; $display("FAIL lu_pre_stall got %b want 0", StallF); end
    tick(); drive(rType(7'b0, 5'd2, 5'd5, 3'b000, 5'd6));
    nChecks++; if ({StallF, StallD, FlushD} !== 3'b110) begin nFails++; $display("FAIL lu_stall got %b want 110", {StallF, StallD, FlushD}); end
    tick();
    nChecks++; if ({StallF, StallD} !== 2'b00) begin nFails++; $display("FAIL lu_stall_once got %b want 00", {StallF, StallD}); end
    nChecks++; if (ALUSrcE !== 1'b0) begin nFails++; $display("FAIL lu_bubble_alusrc got %b want 0", ALUSrcE); end
    tick(); drive(32'h0);
    nChecks++; if (ForwardAE !== 2'b01) begin nFails++; $display("FAIL lu_fwdA got %b want 01", ForwardAE); end
    nChecks++; if (ForwardBE !== 2'b00) begin nFails++; $display("FAIL lu_fwdB got %b want 00", ForwardBE); end
    nChecks++; if ({ResultSrcW, RdW} !== {2'b01, 5'd5}) begin nFails++; $display("FAIL lu_w got %b/%0d want 01/5", ResultSrcW, RdW); end
  endtask

  task automatic test_back_to_back();
    drainPipe();
    drive(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd4));
    tick(); drive(rType(7'b0100000, 5'd4, 5'd4, 3'b000, 5'd7));
    nChecks++; if (StallF !== 1'b0) begin nFails++; $display("FAIL b2b_nostall got %b want 0", StallF); end
    tick(); drive(rType(7'b0, 5'd7, 5'd4, 3'b100, 5'd9));
    nChecks++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin nFails++; $display("FAIL b2b_fwd got %b want 1010", {ForwardAE, ForwardBE}); end
    nChecks++; if (ALUControlE !== 4'b0001) begin nFails++; $display("FAIL b2b_sub got %b want 0001", ALUControlE); end
    tick(); drive(32'h0);
    nChecks++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin nFails++; $display("FAIL b2b_mw_fwd got %b want 0110", {ForwardAE, ForwardBE}); end
    nChecks++; if (ALUControlE !== 4'b0100) begin nFails++; $display("FAIL b2b_xor got %b want 0100", ALUControlE); end
    drainPipe();
    drive(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd4));
    tick(); drive(rType(7'b0, 5'd1, 5'd4, 3'b000, 5'd4));
    tick(); drive(rType(7'b0, 5'd0, 5'd4, 3'b110, 5'd10));
    tick(); drive(32'h0);
    nChecks++; if ({ForwardAE, ForwardBE} !== 4'b1000) begin nFails++; $display("FAIL prio_fwd got %b want 1000", {ForwardAE, ForwardBE}); end
    nChecks++; if (ALUControlE !== 4'b0011) begin nFails++; $display("FAIL prio_or got %b want 0011", ALUControlE); end
  endtask

  task automatic test_branch();
    logic [5:0] brTab [10];
    brTab = '{6'b000_1_0_1, 6'b000_0_1_0, 6'b001_0_0_1, 6'b001_1_1_0, 6'b100_0_0_0,
              6'b100_1_1_1, 6'b101_0_1_0, 6'b101_1_0_1, 6'b010_1_1_0, 6'b110_1_1_0};
    drainPipe();
    for (int i = 0; i < 10; i++) begin
      ZeroE = 1'b0; LtE = 1'b0;
      drive(bType(5'd2, 5'd1, brTab[i][5:3]));
      nChecks++; if (ImmSrcD !== 3'b010) begin nFails++; $display("FAIL br%0d_imm got %b want 010", i, ImmSrcD); end
      tick();
      ZeroE = brTab[i][2]; LtE = brTab[i][1];
      drive(iType(12'd1, 5'd1, 3'b000, 5'd12, 7'b0010011));
      nChecks++; if ({PCSrcE, FlushD} !== {2{brTab[i][0]}}) begin
        nFails++; $display("FAIL br%0d_taken got %b want %b", i, {PCSrcE, FlushD}, {2{brTab[i][0]}});
      end
      tick(); drive(32'h0);
      nChecks++; if (ALUSrcE !== !brTab[i][0]) begin nFails++; $display("FAIL br%0d_flushE got %b want %b", i, ALUSrcE, !brTab[i][0]); end
      tick();
    end
  endtask

  task automatic test_jumps();
    drainPipe();
    drive(iType(12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111));
    nChecks++; if (ImmSrcD !== 3'b000) begin nFails++; $display("FAIL jalr_imm got %b want 000", ImmSrcD); end
    tick(); drive(32'h0);
    nChecks++; if ({PCSrcE, PCTgtSrcE, ALUSrcE, FlushD} !== 4'b1111) begin
      nFails++; $display("FAIL jalr_e got %b want 1111", {PCSrcE, PCTgtSrcE, ALUSrcE, FlushD});
    end
    tick(); tick();
    nChecks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd1}) begin
      nFails++; $display("FAIL jalr_w got %b/%b/%0d want 1/10/1", RegWriteW, ResultSrcW, RdW);
    end
    drainPipe();
    drive({20'h0, 5'd2, 7'b1101111});
    nChecks++; if (ImmSrcD !== 3'b011) begin nFails++; $display("FAIL jal_imm got %b want 011", ImmSrcD); end
    tick(); drive(32'h0);
    nChecks++; if ({PCSrcE, PCTgtSrcE} !== 2'b10) begin nFails++; $display("FAIL jal_e got %b want 10", {PCSrcE, PCTgtSrcE}); end
  endtask

  task automatic test_mem_illegal_lui();
    drainPipe();
    drive({7'b0, 5'd2, 5'd1, 3'b010, 5'b0, 7'b0100011});
    nChecks++; if (ImmSrcD !== 3'b001) begin nFails++; $display("FAIL sw_imm got %b want 001", ImmSrcD); end
    tick(); drive(32'hFFFF_FF80);
    nChecks++; if (ALUSrcE !== 1'b1) begin nFails++; $display("FAIL sw_alusrc got %b want 1", ALUSrcE); end
    tick(); drive({20'h12345, 5'd13, 7'b0110111});
    nChecks++; if ({ALUSrcE, ALUControlE, PCSrcE, PCTgtSrcE} !== 7'b0) begin
      nFails++; $display("FAIL ill_e got %b want 0", {ALUSrcE, ALUControlE, PCSrcE, PCTgtSrcE});
    end
    nChecks++; if (MemWriteM !== 1'b1) begin nFails++; $display("FAIL sw_memwr got %b want 1", MemWriteM); end
    nChecks++; if (ImmSrcD !== 3'b100) begin nFails++; $display("FAIL lui_imm got %b want 100", ImmSrcD); end
    tick(); drive(32'h0);
    nChecks++; if (MemWriteM !== 1'b0) begin nFails++; $display("FAIL ill_memwr got %b want 0", MemWriteM); end
    nChecks++; if (RegWriteW !== 1'b0) begin nFails++; $display("FAIL sw_regwr got %b want 0", RegWriteW); end
    tick();
    nChecks++; if ({RegWriteW, ResultSrcW} !== 3'b000) begin nFails++; $display("FAIL ill_w got %b want 000", {RegWriteW, ResultSrcW}); end
    tick();
    nChecks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b11, 5'd13}) begin
      nFails++; $display("FAIL lui_w got %b/%b/%0d want 1/11/13", RegWriteW, ResultSrcW, RdW);
    end
  endtask

  task automatic test_no_forward();
    drainPipe();
    drive(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd4));
    tick(); drive(rType(7'b0, 5'd0, 5'd4, 3'b110, 5'd8));
    nChecks++; if ({nStallF, nStallD, nForwardAE} !== 4'b1100) begin
      nFails++; $display("FAIL nf_stallE got %b want 1100", {nStallF, nStallD, nForwardAE});
    end
    tick();
    nChecks++; if ({nStallF, nStallD, nForwardAE} !== 4'b1100) begin
      nFails++; $display("FAIL nf_stallM got %b want 1100", {nStallF, nStallD, nForwardAE});
    end
    tick();
    nChecks++; if ({nStallF, nForwardAE} !== 3'b000) begin nFails++; $display("FAIL nf_release got %b want 000", {nStallF, nForwardAE}); end
    tick(); drive(32'h0);
    nChecks++; if ({nALUControlE, nForwardAE} !== 6'b0011_00) begin
      nFails++; $display("FAIL nf_or_e got %b want 001100", {nALUControlE, nForwardAE});
    end
    drainPipe();
    drive(rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd0));
    tick(); drive(rType(7'b0, 5'd0, 5'd0, 3'b000, 5'd11));
    nChecks++; if (nStallF !== 1'b0) begin nFails++; $display("FAIL x0_nf_stall got %b want 0", nStallF); end
    tick(); drive(32'h0);
    nChecks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin nFails++; $display("FAIL x0_fwd got %b want 0000", {ForwardAE, ForwardBE}); end
    nChecks++; if (nStallF !== 1'b0) begin nFails++; $display("FAIL x0_nf_stallM got %b want 0", nStallF); end
  endtask

  initial begin
    reset  = 1'b0;
    InstrD = 32'h0;
    ZeroE  = 1'b0;
    LtE    = 1'b0;
    test_reset();
    test_mid_reset();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_jumps();
    test_mem_illegal_lui();
    test_no_forward();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
